reaction_timer: RTL and testbench

- Timing datapath for the reaction-time game. It sits directly below the reaction control FSM, consumes that FSM's startDownCount, startUpCount and loadScore strobes, and returns downCountComplete.
- Generates a pseudo-random red-light delay, measures the green-to-press reaction time in milliseconds, and holds the last and best scores for the display stage.

---
 rtl/reaction_pkg.sv | 13 +
 rtl/ms_tick_gen.sv | 29 ++
 rtl/reaction_timer.sv | 105 ++++++++++
 tb/tb_reaction_timer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared constants for the reaction-time game datapath: millisecond width,
// saturation limit, LFSR feedback taps and the best-score sentinel.
package reaction_pkg;

  localparam int MS_W = 14;
  localparam int MS_MAX = 9999;

  // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [MS_W-1:0] BEST_INIT = 14'h3FFF;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV clocks, with a
// synchronous clear that restarts the period from zero.
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic iResetn,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  // While clear is held the count is treated as zero, so no tick escapes.
  assign tick = ~clear & (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// Timing datapath for the reaction game: random red-light down count,
// millisecond reaction up count, and last/best score registers.
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int          CLK_FREQ     = 50000000,
  parameter int          TICK_DIV     = CLK_FREQ / 1000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RAND_BITS    = 11,
  parameter int          MAX_MS       = MS_MAX,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic            clk,
  input  logic            iResetn,
  input  logic            startDownCount,
  input  logic            startUpCount,
  input  logic            loadScore,
  output logic            downCountComplete,
  output logic [MS_W-1:0] liveMs,
  output logic [MS_W-1:0] score,
  output logic [MS_W-1:0] bestScore,
  output logic            scoreValid
);

  logic            tick;
  logic [15:0]     lfsr;
  logic [MS_W-1:0] randOff;
  logic [MS_W-1:0] delayLoad;
  logic [MS_W-1:0] downCnt;
  logic            armed;
  logic            startUpCountD;
  logic            upEdge;
  logic            running;

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) uTickGen (
    .clk     (clk),
    .iResetn (iResetn),
    .clear   (startDownCount | startUpCount),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) lfsr <= LFSR_SEED;
    else          lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  generate
    if (RAND_BITS == 0) begin : gFixedDelay
      assign randOff = '0;
    end else begin : gRandDelay
      assign randOff = MS_W'(lfsr[RAND_BITS-1:0]);
    end
  endgenerate

  assign delayLoad = MS_W'(MIN_DELAY_MS) + randOff;

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      downCnt <= '0;
      armed   <= 1'b0;
    end else if (startDownCount) begin
      downCnt <= delayLoad;
      armed   <= 1'b1;
    end else if (tick && (downCnt != '0)) begin
      downCnt <= downCnt - 1'b1;
    end
  end

  assign downCountComplete = armed & (downCnt == '0) & ~startDownCount;

  assign upEdge = startUpCountD & ~startUpCount;

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      startUpCountD <= 1'b0;
      running       <= 1'b0;
      liveMs        <= '0;
    end else begin
      startUpCountD <= startUpCount;
      if (startUpCount) begin
        running <= 1'b0;
        liveMs  <= '0;
      end else begin
        if (upEdge)         running <= 1'b1;
        else if (loadScore) running <= 1'b0;
        if (tick && running && (liveMs < MS_W'(MAX_MS)))
          liveMs <= liveMs + 1'b1;
      end
    end
  end

  // Capture uses the register value before any same-cycle tick or clear.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      score      <= '0;
      bestScore  <= BEST_INIT;
      scoreValid <= 1'b0;
    end else if (loadScore) begin
      score      <= liveMs;
      scoreValid <= 1'b1;
      if (liveMs < bestScore) bestScore <= liveMs;
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer: delay, reaction timing, best score,
// saturation, asynchronous reset and randomised delay range.
module tb_reaction_timer;
  import reaction_pkg::*;

  logic            clk;
  logic            iResetn;
  logic            startDownCount;
  logic            startUpCount;
  logic            loadScore;
  logic            downCountComplete;
  logic [MS_W-1:0] liveMs;
  logic [MS_W-1:0] score;
  logic [MS_W-1:0] bestScore;
  logic            scoreValid;

  logic            rStartDownCount;
  logic            rStartUpCount;
  logic            rLoadScore;
  logic            rDownCountComplete;
  logic [MS_W-1:0] rLiveMs;
  logic [MS_W-1:0] rScore;
  logic [MS_W-1:0] rBestScore;
  logic            rScoreValid;

  int total = 0;
  int bad   = 0;

  reaction_timer #(
    .CLK_FREQ(4000), .TICK_DIV(4), .MIN_DELAY_MS(5), .RAND_BITS(0), .MAX_MS(20)
  ) dut (
    .clk               (clk),
    .iResetn           (iResetn),
    .startDownCount    (startDownCount),
    .startUpCount      (startUpCount),
    .loadScore         (loadScore),
    .downCountComplete (downCountComplete),
    .liveMs            (liveMs),
    .score             (score),
    .bestScore         (bestScore),
    .scoreValid        (scoreValid)
  );

  reaction_timer #(
    .CLK_FREQ(4000), .TICK_DIV(4), .MIN_DELAY_MS(5), .RAND_BITS(3), .MAX_MS(20)
  ) dutRand (
    .clk               (clk),
    .iResetn           (iResetn),
    .startDownCount    (rStartDownCount),
    .startUpCount      (rStartUpCount),
    .loadScore         (rLoadScore),
    .downCountComplete (rDownCountComplete),
    .liveMs            (rLiveMs),
    .score             (rScore),
    .bestScore         (rBestScore),
    .scoreValid        (rScoreValid)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver: one reaction round, loadScore sampled on the nClk-th clock after release
  task automatic play_round(input int nClk);
    startUpCount = 1'b1;
    cyc(2);
    startUpCount = 1'b0;
    cyc(nClk - 1);
    loadScore = 1'b1;
    cyc(1);
    loadScore = 1'b0;
  endtask

  initial begin
    int seenHigh;
    int k;
    int delayMs;
    logic [15:0] seenMask;
    int distinct;

    iResetn = 1'b0;
    startDownCount = 1'b0;
    startUpCount = 1'b0;
    loadScore = 1'b0;
    rStartDownCount = 1'b0;
    rStartUpCount = 1'b0;
    rLoadScore = 1'b0;
    cyc(3);
    iResetn = 1'b1;
    cyc(1);

    check("rst_complete", 32'(downCountComplete), 32'd0);
    check("rst_liveMs", 32'(liveMs), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_best", 32'(bestScore), 32'h3FFF);
    check("rst_valid", 32'(scoreValid), 32'd0);

    seenHigh = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (downCountComplete) seenHigh = 1;
    end
    check("idle_no_complete", 32'(seenHigh), 32'd0);

    // Red-light delay: 5 ms of 4 clocks each after release
    startDownCount = 1'b1;
    cyc(3);
    startDownCount = 1'b0;
    cyc(19);
    check("delay_clk19", 32'(downCountComplete), 32'd0);
    cyc(1);
    check("delay_clk20", 32'(downCountComplete), 32'd1);
    cyc(10);
    check("delay_hold", 32'(downCountComplete), 32'd1);
    startDownCount = 1'b1;
    #1;
    check("delay_drop", 32'(downCountComplete), 32'd0);
    cyc(1);
    startDownCount = 1'b0;

    // Round 1: 7 ms
    startUpCount = 1'b1;
    cyc(2);
    startUpCount = 1'b0;
    cyc(28);
    check("r1_live", 32'(liveMs), 32'd7);
    loadScore = 1'b1;
    cyc(1);
    loadScore = 1'b0;
    check("r1_score", 32'(score), 32'd7);
    check("r1_valid", 32'(scoreValid), 32'd1);
    check("r1_best", 32'(bestScore), 32'd7);
    cyc(12);
    check("r1_frozen", 32'(liveMs), 32'd7);

    play_round(37);
    check("r2_score", 32'(score), 32'd9);
    check("r2_best", 32'(bestScore), 32'd7);

    play_round(13);
    check("r3_score", 32'(score), 32'd3);
    check("r3_best", 32'(bestScore), 32'd3);

    // Saturation at MAX_MS
    startUpCount = 1'b1;
    cyc(2);
    startUpCount = 1'b0;
    cyc(200);
    check("sat_live", 32'(liveMs), 32'd20);
    loadScore = 1'b1;
    cyc(1);
    loadScore = 1'b0;
    check("sat_score", 32'(score), 32'd20);
    check("sat_best", 32'(bestScore), 32'd3);

    // Asynchronous reset in the middle of both counts
    startDownCount = 1'b1;
    startUpCount = 1'b1;
    cyc(2);
    startDownCount = 1'b0;
    startUpCount = 1'b0;
    cyc(17);
    check("mid_live", 32'(liveMs), 32'd4);
    check("mid_complete", 32'(downCountComplete), 32'd0);
    #2;
    iResetn = 1'b0;
    #1;
    check("arst_complete", 32'(downCountComplete), 32'd0);
    check("arst_liveMs", 32'(liveMs), 32'd0);
    check("arst_score", 32'(score), 32'd0);
    check("arst_best", 32'(bestScore), 32'h3FFF);
    check("arst_valid", 32'(scoreValid), 32'd0);
    @(negedge clk);
    iResetn = 1'b1;
    cyc(40);
    check("post_complete", 32'(downCountComplete), 32'd0);
    check("post_valid", 32'(scoreValid), 32'd0);
    check("post_liveMs", 32'(liveMs), 32'd0);

    // Randomised delay: every delay within [5,12] ms
    seenMask = '0;
    for (int r = 0; r < 8; r++) begin
      cyc(r + 1);
      rStartDownCount = 1'b1;
      cyc(1);
      rStartDownCount = 1'b0;
      k = 0;
      while (k < 100) begin
        cyc(1);
        k++;
        if (rDownCountComplete) break;
      end
      delayMs = k / 4;
      check("rand_whole_ms", 32'(k % 4), 32'd0);
      check("rand_in_range", 32'((delayMs >= 5) && (delayMs <= 12)), 32'd1);
      if (delayMs < 16) seenMask[delayMs] = 1'b1;
    end
    distinct = $countones(seenMask);
    check("rand_distinct", 32'(distinct >= 3), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
